// File: rtl/tts_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encodings and
// the supported range of function input counts.
package tts_pkg;

  typedef enum logic [1:0] {
    TTS_IDLE  = 2'd0,
    TTS_SWEEP = 2'd1,
    TTS_DONE  = 2'd2
  } tts_state_t;

  localparam int N_IN_MIN = 1;
  localparam int N_IN_MAX = 8;

endpackage

// File: rtl/minterm_select.sv
// Picks the output bit of a Boolean function, given as a minterm mask, for
// one input combination.
module minterm_select #(
  parameter int N_IN = 3
) (
  input  logic [(1<<N_IN)-1:0] mask,
  input  logic [N_IN-1:0]      idx,
  output logic                 bit_out
);

  assign bit_out = mask[idx];

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input combination of two N_IN-input functions, streams both
// outputs per combination and accumulates mismatch / ones / first-mismatch.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int N_IN = 3,
  localparam int IDX_W  = N_IN,
  localparam int CNT_W  = N_IN + 1,
  localparam int MASK_W = 1 << N_IN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop_first,
  input  logic [MASK_W-1:0] mask_a,
  input  logic [MASK_W-1:0] mask_b,
  output logic              busy,
  output logic              done,
  output logic              valid_out,
  output logic [IDX_W-1:0]  idx_out,
  output logic              a_out,
  output logic              b_out,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [CNT_W-1:0]  ones_a,
  output logic [IDX_W-1:0]  first_mm,
  output logic              first_mm_vld,
  output logic              equivalent
);

  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  tts_state_t        state_q, state_d;
  logic [MASK_W-1:0] mask_a_q, mask_b_q;
  logic              stop_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  mm_cnt_q, ones_q;
  logic [IDX_W-1:0]  first_mm_q;
  logic              first_vld_q;
  logic              equiv_q;
  logic              a_bit, b_bit, mism, last_idx;

  minterm_select #(.N_IN(N_IN)) u_sel_a (
    .mask    (mask_a_q),
    .idx     (idx_q),
    .bit_out (a_bit)
  );

  minterm_select #(.N_IN(N_IN)) u_sel_b (
    .mask    (mask_b_q),
    .idx     (idx_q),
    .bit_out (b_bit)
  );

  assign mism     = a_bit ^ b_bit;
  assign last_idx = (idx_q == IDX_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TTS_IDLE:  if (start) state_d = TTS_SWEEP;
      TTS_SWEEP: if (last_idx || (stop_q && mism)) state_d = TTS_DONE;
      TTS_DONE:  state_d = TTS_IDLE;
      default:   state_d = TTS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= TTS_IDLE;
      mask_a_q    <= '0;
      mask_b_q    <= '0;
      stop_q      <= 1'b0;
      idx_q       <= '0;
      mm_cnt_q    <= '0;
      ones_q      <= '0;
      first_mm_q  <= '0;
      first_vld_q <= 1'b0;
      equiv_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == TTS_IDLE && start) begin
        mask_a_q    <= mask_a;
        mask_b_q    <= mask_b;
        stop_q      <= stop_first;
        idx_q       <= '0;
        mm_cnt_q    <= '0;
        ones_q      <= '0;
        first_mm_q  <= '0;
        first_vld_q <= 1'b0;
        equiv_q     <= 1'b0;
      end else if (state_q == TTS_SWEEP) begin
        ones_q <= ones_q + CNT_W'(a_bit);
        if (mism) begin
          mm_cnt_q <= mm_cnt_q + CNT_W'(1);
          if (!first_vld_q) begin
            first_mm_q  <= idx_q;
            first_vld_q <= 1'b1;
          end
        end
        // idx stays on the final combination so it can be read back after the sweep
        if (state_d == TTS_SWEEP) idx_q <= idx_q + IDX_W'(1);
        else                      equiv_q <= (mm_cnt_q == '0) && !mism;
      end
    end
  end

  assign busy         = (state_q == TTS_SWEEP);
  assign valid_out    = (state_q == TTS_SWEEP);
  assign done         = (state_q == TTS_DONE);
  assign idx_out      = idx_q;
  assign a_out        = a_bit;
  assign b_out        = b_bit;
  assign mismatch_cnt = mm_cnt_q;
  assign ones_a       = ones_q;
  assign first_mm     = first_mm_q;
  assign first_mm_vld = first_vld_q;
  assign equivalent   = equiv_q;

endmodule
